// File: rtl/pgm_video_pkg.sv
// Shared types and constants for the PGM video pipeline graphics fetch path.
package pgm_video_pkg;

    localparam int GFX_ADDR_W = 29;
    localparam int GFX_DATA_W = 64;
    localparam int GFX_WD_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        SPR  = 1'b0,
        TILE = 1'b1
    } gfx_req_id_t;

    // Winner selection. With rotation enabled, a tie goes to whoever did not
    // win last; a lone requester always wins.
    function automatic gfx_req_id_t pick_winner(input logic spr, input logic tile,
                                                input gfx_req_id_t last, input bit rr);
        if (spr && tile && rr)
            return (last == SPR) ? TILE : SPR;
        return spr ? SPR : TILE;
    endfunction

endpackage

// File: rtl/pgm_gfx_mem_arbiter.sv
// Two-port read arbiter/sequencer for the graphics DDRAM read channel.
// Sprite and tile fetchers share one 64-bit read port; one read per grant,
// data returned to the granted requester, watchdog abandons lost reads.
// Optional build macro: PGM_ARB_ROUND_ROBIN_EN (round-robin on ties;
// otherwise fixed priority, sprite over tile).
module pgm_gfx_mem_arbiter
    import pgm_video_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spr_req,
    input  logic [GFX_ADDR_W-1:0] spr_addr,
    output logic                  spr_valid,
    input  logic                  tile_req,
    input  logic [GFX_ADDR_W-1:0] tile_addr,
    output logic                  tile_valid,
    output logic [GFX_DATA_W-1:0] rd_data,
    output logic                  ddram_rd,
    output logic [GFX_ADDR_W-1:0] ddram_addr,
    input  logic                  ddram_busy,
    input  logic [GFX_DATA_W-1:0] ddram_dout,
    input  logic                  ddram_dout_ready,
    output logic                  timeout_err,
    output logic                  owner
);

`ifdef PGM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    // Watchdog value seen in the TIMEOUT-th WAIT cycle (counts from 0).
    localparam logic [GFX_WD_W-1:0] WD_LAST = 8'(TIMEOUT - 1);

    arb_state_t          state, state_nxt;
    logic [GFX_WD_W-1:0] wd;
    gfx_req_id_t         owner_id, last_win, win_id;
    logic                any_req, issue_go, rsp_take, wd_hit, wd_expire;

    // Arbitration and per-state event decode.
    always_comb begin
        any_req   = spr_req | tile_req;
        win_id    = pick_winner(spr_req, tile_req, last_win, RR_EN);
        issue_go  = (state == ISSUE) && !ddram_busy;
        rsp_take  = (state == WAIT) && ddram_dout_ready;
        wd_hit    = (wd == WD_LAST);
        wd_expire = (state == WAIT) && !ddram_dout_ready && wd_hit;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; a response in the expiry cycle beats the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   if (!ddram_busy) state_nxt = WAIT;
            WAIT:    if (ddram_dout_ready || wd_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read strobe: one cycle, only when the port can accept it.
    always_comb begin
        ddram_rd = issue_go && !reset;
    end

    // Grant latch, watchdog, returned data, result pulses and rotation memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            ddram_addr  <= '0;
            owner_id    <= SPR;
            last_win    <= TILE;
            wd          <= '0;
            rd_data     <= '0;
            spr_valid   <= 1'b0;
            tile_valid  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            spr_valid   <= rsp_take && (owner_id == SPR);
            tile_valid  <= rsp_take && (owner_id == TILE);
            timeout_err <= wd_expire;

            if (state == IDLE && any_req) begin
                owner_id   <= win_id;
                ddram_addr <= (win_id == TILE) ? tile_addr : spr_addr;
            end

            if (issue_go)
                wd <= '0;
            else if (state == WAIT && !ddram_dout_ready)
                wd <= wd + 8'd1;

            if (rsp_take)
                rd_data <= ddram_dout;

            if (rsp_take || wd_expire)
                last_win <= owner_id;
        end
    end

    assign owner = owner_id;

endmodule

// File: tb/tb_pgm_gfx_mem_arbiter.sv
// Scoreboard bench for pgm_gfx_mem_arbiter (TIMEOUT=8).
module tb_pgm_gfx_mem_arbiter;

    localparam int TO = 8;
`ifdef PGM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        spr_req, tile_req;
    logic [28:0] spr_addr, tile_addr;
    logic        spr_valid, tile_valid;
    logic [63:0] rd_data;
    logic        ddram_rd;
    logic [28:0] ddram_addr;
    logic        ddram_busy;
    logic [63:0] ddram_dout;
    logic        ddram_dout_ready;
    logic        timeout_err;
    logic        owner;

    pgm_gfx_mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .spr_req(spr_req), .spr_addr(spr_addr), .spr_valid(spr_valid),
        .tile_req(tile_req), .tile_addr(tile_addr), .tile_valid(tile_valid),
        .rd_data(rd_data), .ddram_rd(ddram_rd), .ddram_addr(ddram_addr),
        .ddram_busy(ddram_busy), .ddram_dout(ddram_dout),
        .ddram_dout_ready(ddram_dout_ready), .timeout_err(timeout_err),
        .owner(owner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [28:0] addr; logic own; } rd_exp_t;
    typedef struct { int kind; logic [63:0] data; } rsp_exp_t;   // 0 spr, 1 tile, 2 timeout
    typedef struct { int delay; logic [63:0] word; } drv_t;      // delay 0: never answer

    rd_exp_t  rd_q[$];
    rsp_exp_t rsp_q[$];
    drv_t     drv_q[$];

    int checks = 0, errors = 0;
    int spr_target = 0, tile_target = 0, spr_done = 0, tile_done = 0;
    int last_rd_cyc = -100, last_rdy_cyc = -100;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] word_of(input int i);
        return 64'hC0DE_0000_0000_0000 | 64'(i * 32'h1111_0101);
    endfunction

    // Monitor, DDRAM responder and requester models, all on the falling edge.
    initial begin
        int       cnt = 0;
        logic [63:0] w = '0;
        rd_exp_t  e;
        rsp_exp_t r;
        drv_t     d;
        int       kind;
        ddram_dout_ready = 1'b0;
        ddram_dout       = '0;
        spr_req          = 1'b0;
        tile_req         = 1'b0;
        forever begin
            @(negedge clk);
            if (ddram_rd) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    e = rd_q.pop_front();
                    chk("rd_addr", 64'(ddram_addr), 64'(e.addr));
                    chk("rd_owner", 64'(owner), 64'(e.own));
                    chk("rd_spacing", 64'(cyc - last_rd_cyc >= 3), 1);
                end
                last_rd_cyc = cyc;
            end
            if (spr_valid && tile_valid) chk("both_valid", 1, 0);
            if (spr_valid || tile_valid || timeout_err) begin
                kind = timeout_err ? 2 : (tile_valid ? 1 : 0);
                if (rsp_q.size() == 0) chk("rsp_unexpected", 64'(kind), 64'hFF);
                else begin
                    r = rsp_q.pop_front();
                    chk("rsp_kind", 64'(kind), 64'(r.kind));
                    if (kind < 2) begin
                        chk("rd_data", rd_data, r.data);
                        chk("valid_latency", 64'(cyc), 64'(last_rdy_cyc + 1));
                    end else
                        chk("timeout_latency", 64'(cyc), 64'(last_rd_cyc + TO + 1));
                end
            end
            // responder
            ddram_dout_ready = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    ddram_dout_ready = 1'b1;
                    ddram_dout       = w;
                    last_rdy_cyc     = cyc;
                end
            end
            if (ddram_rd && drv_q.size() != 0) begin
                d   = drv_q.pop_front();
                cnt = d.delay;
                w   = d.word;
            end
            // requesters hold req until their own valid
            if (spr_valid)  spr_done++;
            if (tile_valid) tile_done++;
            spr_req  = (spr_done < spr_target);
            tile_req = (tile_done < tile_target);
        end
    end

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((rd_q.size() != 0 || rsp_q.size() != 0 || spr_done < spr_target ||
                tile_done < tile_target) && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk(nm, 64'(n < 300), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic exp_txn(input logic own, input logic [28:0] a, input int dly, input logic [63:0] wd);
        rd_q.push_back('{addr: a, own: own});
        rsp_q.push_back('{kind: int'(own), data: wd});
        drv_q.push_back('{delay: dly, word: wd});
    endtask

    initial begin
        int n, bad, first;
        bit seen;
        logic own;
        reset = 1'b1; ddram_busy = 1'b0;
        spr_addr = '0; tile_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ddram_rd", 64'(ddram_rd), 0);
        chk("rst_ddram_addr", 64'(ddram_addr), 0);
        chk("rst_valids", 64'({spr_valid, tile_valid}), 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_timeout_err", 64'(timeout_err), 0);
        chk("rst_owner", 64'(owner), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // single sprite read
        spr_addr = 29'h0001000;
        exp_txn(1'b0, 29'h0001000, 4, 64'h1122_3344_5566_7788);
        spr_target++;
        wait_idle("t1_idle");
        chk("t1_tile_untouched", 64'(tile_done), 0);

        // simultaneous requests (after t1, rotation would favour tile)
        spr_addr  = 29'h0002000;
        tile_addr = 29'h0003000;
        first = RR ? 1 : 0;
        exp_txn(first[0], first[0] ? tile_addr : spr_addr, 3, 64'hAAAA_0000_0000_0001);
        exp_txn(!first[0], first[0] ? spr_addr : tile_addr, 5, 64'hBBBB_0000_0000_0002);
        spr_target++; tile_target++;
        wait_idle("t2_idle");

        // fresh reset, both held for six transactions at minimum latency
        reset = 1'b1;
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        spr_addr  = 29'h0004440;
        tile_addr = 29'h1FFFFFF;
        for (int i = 0; i < 6; i++) begin
            own = RR ? i[0] : (i >= 3);
            exp_txn(own, own ? tile_addr : spr_addr, 1, word_of(i));
        end
        spr_target += 3; tile_target += 3;
        wait_idle("t3_idle");

        // busy held ten cycles in ISSUE
        spr_addr = 29'h0ABCDE0;
        exp_txn(1'b0, spr_addr, 2, 64'h0F0F_F0F0_1234_5678);
        ddram_busy = 1'b1;
        spr_target++;
        n = cyc; bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ddram_rd !== 1'b0 || ddram_addr !== spr_addr) bad++;
        end
        @(posedge clk); #1;
        ddram_busy = 1'b0;
        chk("busy_hold_stable", 64'(bad), 0);
        wait_idle("t4_idle");
        chk("busy_rd_cycle", 64'(last_rd_cyc), 64'(n + 11));

        // watchdog expiry, stray late response during ISSUE, then re-issue
        spr_addr = 29'h1555555;
        rd_q.push_back('{addr: spr_addr, own: 1'b0});
        rsp_q.push_back('{kind: 2, data: '0});
        drv_q.push_back('{delay: 10, word: 64'hDEAD_DEAD_DEAD_DEAD});
        exp_txn(1'b0, spr_addr, 4, 64'h5A5A_A5A5_0000_FFFF);
        spr_target++;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (timeout_err) seen = 1'b1;
        end
        chk("t5_timeout_seen", 64'(seen), 1);
        @(posedge clk); #1; ddram_busy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; ddram_busy = 1'b0;
        wait_idle("t5_idle");

        // reset during WAIT, response arrives one cycle after reset
        spr_addr = 29'h0000040;
        rd_q.push_back('{addr: spr_addr, own: 1'b0});
        drv_q.push_back('{delay: 3, word: 64'h0BAD_0BAD_0BAD_0BAD});
        spr_target++;
        n = spr_done;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ddram_rd) seen = 1'b1;
        end
        chk("t6_rd_seen", 64'(seen), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        spr_target = spr_done;
        @(posedge clk); #1;
        chk("t6_ddram_rd", 64'(ddram_rd), 0);
        chk("t6_ddram_addr", 64'(ddram_addr), 0);
        chk("t6_rd_data", rd_data, 0);
        chk("t6_owner", 64'(owner), 0);
        reset = 1'b0;
        repeat (6) @(posedge clk); #1;
        chk("t6_no_valid", 64'(spr_done - n), 0);
        chk("t6_rd_data_after", rd_data, 0);
        chk("t6_no_rd", 64'(ddram_rd), 0);

        chk("end_rd_q", 64'(rd_q.size()), 0);
        chk("end_rsp_q", 64'(rsp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
